// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control FSM of the simple processor.
// Requests an IR load in T0, decodes the latched instruction in T1 and
// sequences register file, bus mux, A, ALU and G enables through T2/T3.
// Optional feature: define UNIDADE_CONTROLE_MVNZ_EN to decode opcode 0100 as mvnz.
//
// state | meaning
// T0    | fetch: IRin follows Run, leave T0 only when Run=1
// T1    | decode; mv/mvi/mvnz/NOP complete here, add/sub load A
// T2    | add/sub: Y onto the bus, G <= A +/- bus
// T3    | add/sub: G onto the bus, write back to X
module unidade_controle #(
    parameter int NREG = 8,
    parameter int OPW  = 4
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [9:0]      IR,
    input  logic            Gnz,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            DINout,
    output logic            Gout,
    output logic            Ain,
    output logic            Gin,
    output logic            AddSub,
    output logic            Done,
    output logic [1:0]      Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam logic [OPW-1:0]  OP_MV  = OPW'(0);
    localparam logic [OPW-1:0]  OP_MVI = OPW'(1);
    localparam logic [OPW-1:0]  OP_ADD = OPW'(2);
    localparam logic [OPW-1:0]  OP_SUB = OPW'(3);
`ifdef UNIDADE_CONTROLE_MVNZ_EN
    localparam logic [OPW-1:0]  OP_MVNZ = OPW'(4);
`endif
    localparam logic [NREG-1:0] ONE    = NREG'(1);

    tstep_t          state;
    logic [OPW-1:0]  opcode;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic [NREG-1:0] x_hot;
    logic [NREG-1:0] y_hot;
    logic            is_arith;

    assign opcode   = IR[9 -: OPW];
    assign rx       = IR[5:3];
    assign ry       = IR[2:0];
    assign x_hot    = ONE << rx;
    assign y_hot    = ONE << ry;
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign Tstep    = state;

`ifndef UNIDADE_CONTROLE_MVNZ_EN
    // Gnz only matters for mvnz; keep the port without a dangling input.
    logic gnz_unused;
    assign gnz_unused = Gnz;
`endif

    // Step sequencer: T0 waits for Run, add/sub run to T3, everything else ends in T1.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state <= T0;
        end else begin
            case (state)
                T0:      state <= Run ? T1 : T0;
                T1:      state <= is_arith ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Control enables decoded from the current step and the latched instruction; all quiet in reset.
    always_comb begin
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        DINout = 1'b0;
        Gout   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (!Resetn) begin
            case (state)
                T0: begin
                    IRin = Run;
                end
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            Rout = y_hot;
                            Rin  = x_hot;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = x_hot;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout = x_hot;
                            Ain  = 1'b1;
                        end
`ifdef UNIDADE_CONTROLE_MVNZ_EN
                        OP_MVNZ: begin
                            if (Gnz) begin
                                Rout = y_hot;
                                Rin  = x_hot;
                            end
                            Done = 1'b1;
                        end
`endif
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    Rout   = y_hot;
                    Gin    = 1'b1;
                    AddSub = IR[6];
                end
                T3: begin
                    Gout = 1'b1;
                    Rin  = x_hot;
                    Done = 1'b1;
                end
                default: begin
                    IRin = 1'b0;
                end
            endcase
        end
    end

endmodule
